// File: rtl/fpga_led_status_ctrl_pkg.sv
// Shared types for the LED status controller: per-channel LED modes and
// the exit-code blinker state machine.
package fpga_led_status_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PWM   = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        EXIT_IDLE  = 2'b00,
        EXIT_BIT   = 2'b01,
        EXIT_PAUSE = 2'b10
    } exit_state_e;

    localparam int EXIT_CODE_W = 8;

endpackage

// File: rtl/fpga_led_status_ctrl_if.sv
// Bundle of mode/duty/exit-code inputs and LED outputs of the status controller.
interface fpga_led_status_ctrl_if #(
    parameter int NUM_LEDS = 4,
    parameter int PWM_W    = 8
);
    logic [2*NUM_LEDS-1:0] mode_i;
    logic [PWM_W-1:0]      duty_i;
    logic                  exit_valid_i;
    logic [31:0]           exit_value_i;
    logic [NUM_LEDS-1:0]   led_o;
    logic                  exit_led_o;
    logic                  exit_ok_o;

    modport master (
        output mode_i, duty_i, exit_valid_i, exit_value_i,
        input  led_o, exit_led_o, exit_ok_o
    );

    modport slave (
        input  mode_i, duty_i, exit_valid_i, exit_value_i,
        output led_o, exit_led_o, exit_ok_o
    );

endinterface

// File: rtl/fpga_led_exit_blinker.sv
// Serial exit-code blinker: shows the low 8 bits of the exit code MSB first as
// long (1) or short (0) pulses, then a 4-slot gap, repeating while valid.
module fpga_led_exit_blinker
    import fpga_led_status_ctrl_pkg::*;
#(
    parameter int SLOT_W = 24
) (
    input  logic                   clk_gen,
    input  logic                   rst_n,
    input  logic                   exit_valid_i,
    input  logic [EXIT_CODE_W-1:0] exit_code_i,
    output logic                   exit_led_o
);

    localparam logic [SLOT_W-1:0] THR_ONE  = SLOT_W'(3) << (SLOT_W - 2);
    localparam logic [SLOT_W-1:0] THR_ZERO = SLOT_W'(1) << (SLOT_W - 2);

    exit_state_e            state;
    logic [SLOT_W-1:0]      slot_cnt;
    logic [1:0]             pause_slot;
    logic [2:0]             bit_idx;
    logic [EXIT_CODE_W-1:0] code_q;
    logic                   slot_wrap;

    assign slot_wrap = &slot_cnt;

    // Dropping exit_valid_i in any active state returns to IDLE on the next edge.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EXIT_IDLE;
            slot_cnt   <= '0;
            pause_slot <= '0;
            bit_idx    <= 3'd7;
            code_q     <= '0;
            exit_led_o <= 1'b0;
        end else begin
            case (state)
                EXIT_IDLE: begin
                    exit_led_o <= 1'b0;
                    if (exit_valid_i) begin
                        code_q     <= exit_code_i;
                        bit_idx    <= 3'd7;
                        slot_cnt   <= '0;
                        pause_slot <= '0;
                        state      <= EXIT_BIT;
                    end
                end
                EXIT_BIT: begin
                    if (!exit_valid_i) begin
                        exit_led_o <= 1'b0;
                        state      <= EXIT_IDLE;
                    end else begin
                        slot_cnt   <= slot_cnt + SLOT_W'(1);
                        exit_led_o <= code_q[bit_idx] ? (slot_cnt < THR_ONE)
                                                      : (slot_cnt < THR_ZERO);
                        if (slot_wrap) begin
                            bit_idx <= bit_idx - 3'd1;
                            if (bit_idx == 3'd0) begin
                                pause_slot <= '0;
                                state      <= EXIT_PAUSE;
                            end
                        end
                    end
                end
                EXIT_PAUSE: begin
                    exit_led_o <= 1'b0;
                    if (!exit_valid_i) begin
                        state <= EXIT_IDLE;
                    end else begin
                        slot_cnt <= slot_cnt + SLOT_W'(1);
                        if (slot_wrap) begin
                            pause_slot <= pause_slot + 2'd1;
                            if (&pause_slot) begin
                                bit_idx <= 3'd7;
                                state   <= EXIT_BIT;
                            end
                        end
                    end
                end
                default: begin
                    exit_led_o <= 1'b0;
                    state      <= EXIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpga_led_status_ctrl.sv
// LED status controller: per-channel off/on/blink/PWM drive from a shared
// free-running counter, exit-code blinker, and a reset synchroniser.
module fpga_led_status_ctrl
    import fpga_led_status_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CNT_W    = 27,
    parameter int PWM_W    = 8,
    parameter int SLOT_W   = 24
) (
    input  logic                   clk_gen,
    input  logic                   rst_n,
    output logic                   rst_sync_no,
    fpga_led_status_ctrl_if.slave  bus
);

    logic [1:0]          sync_q;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_LEDS-1:0] led_q;
    logic                exit_ok_q;
    logic                exit_led;

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_sync_no = sync_q[1];

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Mode changes never disturb cnt, so blink/PWM phase stays shared across channels.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (led_mode_e'(bus.mode_i[2*i +: 2]))
                    LED_OFF:   led_q[i] <= 1'b0;
                    LED_ON:    led_q[i] <= 1'b1;
                    LED_BLINK: led_q[i] <= cnt[CNT_W-1];
                    LED_PWM:   led_q[i] <= (cnt[PWM_W-1:0] < bus.duty_i);
                    default:   led_q[i] <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            exit_ok_q <= 1'b0;
        end else begin
            exit_ok_q <= bus.exit_valid_i && (bus.exit_value_i == 32'd0);
        end
    end

    fpga_led_exit_blinker #(
        .SLOT_W (SLOT_W)
    ) u_exit_blinker (
        .clk_gen      (clk_gen),
        .rst_n        (rst_n),
        .exit_valid_i (bus.exit_valid_i),
        .exit_code_i  (bus.exit_value_i[EXIT_CODE_W-1:0]),
        .exit_led_o   (exit_led)
    );

    assign bus.led_o      = led_q;
    assign bus.exit_led_o = exit_led;
    assign bus.exit_ok_o  = exit_ok_q;

endmodule

// File: tb/tb_fpga_led_status_ctrl.sv
// Randomised and directed bench for fpga_led_status_ctrl against a cycle-count
// reference model of the LED and exit-code behaviour.
module tb_fpga_led_status_ctrl;

    localparam int NUM_LEDS = 4;
    localparam int CNT_W    = 6;
    localparam int PWM_W    = 4;
    localparam int SLOT_W   = 4;
    localparam int SLOT_LEN = 1 << SLOT_W;
    localparam int PERIOD   = 12 * SLOT_LEN;

    logic clk_gen = 1'b0;
    logic rst_n   = 1'b1;
    logic rst_sync_no;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int                  m_cnt    = 0;
    int                  m_edges  = 0;
    bit                  m_active = 1'b0;
    int                  m_phase  = 0;
    logic [7:0]          m_code   = '0;
    logic [NUM_LEDS-1:0] exp_led  = '0;
    logic                exp_exit = 1'b0;
    logic                exp_ok   = 1'b0;
    logic                exp_sync = 1'b0;

    fpga_led_status_ctrl_if #(.NUM_LEDS(NUM_LEDS), .PWM_W(PWM_W)) bus ();

    fpga_led_status_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .CNT_W    (CNT_W),
        .PWM_W    (PWM_W),
        .SLOT_W   (SLOT_W)
    ) dut (
        .clk_gen     (clk_gen),
        .rst_n       (rst_n),
        .rst_sync_no (rst_sync_no),
        .bus         (bus)
    );

    always #5 clk_gen = ~clk_gen;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2*NUM_LEDS-1:0] mode, input int duty,
                                  input logic valid, input logic [31:0] value);
        bus.mode_i       = mode;
        bus.duty_i       = PWM_W'(duty);
        bus.exit_valid_i = valid;
        bus.exit_value_i = value;
    endtask

    // Predict the next edge from current inputs, advance one clock, compare at the falling edge.
    task automatic step_cycle();
        int p;
        if (!rst_n) begin
            exp_led  = '0;
            exp_exit = 1'b0;
            exp_ok   = 1'b0;
            m_cnt    = 0;
            m_edges  = 0;
            m_active = 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                case (int'(bus.mode_i[2*i +: 2]))
                    0:       exp_led[i] = 1'b0;
                    1:       exp_led[i] = 1'b1;
                    2:       exp_led[i] = ((m_cnt / 32) % 2) == 1;
                    default: exp_led[i] = (m_cnt % 16) < int'(bus.duty_i);
                endcase
            end
            exp_ok = bus.exit_valid_i && (bus.exit_value_i == 32'd0);
            if (!m_active) begin
                exp_exit = 1'b0;
                if (bus.exit_valid_i) begin
                    m_active = 1'b1;
                    m_code   = bus.exit_value_i[7:0];
                    m_phase  = 0;
                end
            end else if (!bus.exit_valid_i) begin
                m_active = 1'b0;
                exp_exit = 1'b0;
            end else begin
                p = m_phase % PERIOD;
                if (p < 8 * SLOT_LEN)
                    exp_exit = (p % SLOT_LEN) < (m_code[7 - p / SLOT_LEN] ? 12 : 4);
                else
                    exp_exit = 1'b0;
                m_phase++;
            end
            m_cnt = (m_cnt + 1) % 64;
            if (m_edges < 2) m_edges++;
        end
        exp_sync = (m_edges >= 2);
        @(posedge clk_gen);
        @(negedge clk_gen);
        check_output("led_o", 32'(bus.led_o), 32'(exp_led));
        check_output("exit_led_o", 32'(bus.exit_led_o), 32'(exp_exit));
        check_output("exit_ok_o", 32'(bus.exit_ok_o), 32'(exp_ok));
        check_output("rst_sync_no", 32'(rst_sync_no), 32'(exp_sync));
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) step_cycle();
    endtask

    task automatic count_high(input int n, input int led, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step_cycle();
            if (led < 0) hi += int'(bus.exit_led_o);
            else         hi += int'(bus.led_o[led]);
        end
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check_output("async_led_o", 32'(bus.led_o), 32'd0);
        check_output("async_exit_led_o", 32'(bus.exit_led_o), 32'd0);
        check_output("async_exit_ok_o", 32'(bus.exit_ok_o), 32'd0);
        check_output("async_rst_sync_no", 32'(rst_sync_no), 32'd0);
        @(negedge clk_gen);
    endtask

    initial begin
        int hi;
        apply_stimulus('0, 0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        $display("[TB] reset phase");
        run_cycles(4);
        rst_n = 1'b1;
        run_cycles(3);

        $display("[TB] fixed channel modes");
        apply_stimulus(8'b11_10_01_00, 4, 1'b0, 32'd0);
        run_cycles(70);
        count_high(16, 3, hi);
        check_output("pwm_duty4_count", 32'(hi), 32'd4);
        count_high(64, 2, hi);
        check_output("blink_count", 32'(hi), 32'd32);

        $display("[TB] PWM duty boundaries");
        apply_stimulus(8'hFF, 0, 1'b0, 32'd0);
        run_cycles(2);
        count_high(16, 0, hi);
        check_output("pwm_duty0_count", 32'(hi), 32'd0);
        apply_stimulus(8'hFF, 15, 1'b0, 32'd0);
        run_cycles(2);
        count_high(16, 1, hi);
        check_output("pwm_duty15_count", 32'(hi), 32'd15);

        $display("[TB] random channel modes");
        for (int r = 0; r < 12; r++) begin
            apply_stimulus(8'($urandom), int'($urandom_range(0, 15)), 1'b0, 32'd0);
            run_cycles(int'($urandom_range(3, 12)));
        end

        $display("[TB] exit code A5");
        apply_stimulus(8'h00, 0, 1'b1, 32'hA5);
        run_cycles(1);
        count_high(PERIOD, -1, hi);
        check_output("exit_a5_high_count", 32'(hi), 32'd64);
        run_cycles(PERIOD + 8);

        $display("[TB] exit valid dropped in slot 3");
        apply_stimulus(8'h00, 0, 1'b0, 32'd0);
        run_cycles(2);
        apply_stimulus(8'h00, 0, 1'b1, 32'hA5);
        run_cycles(1 + 3 * SLOT_LEN + 5);
        apply_stimulus(8'h00, 0, 1'b0, 32'hA5);
        run_cycles(3);

        $display("[TB] exit code zero");
        apply_stimulus(8'h00, 0, 1'b1, 32'd0);
        run_cycles(1);
        count_high(PERIOD, -1, hi);
        check_output("exit_zero_high_count", 32'(hi), 32'd32);
        run_cycles(20);

        $display("[TB] random exit codes");
        for (int r = 0; r < 3; r++) begin
            apply_stimulus(8'($urandom), int'($urandom_range(0, 15)), 1'b0, 32'd0);
            run_cycles(2);
            apply_stimulus(bus.mode_i, int'(bus.duty_i), 1'b1, $urandom);
            run_cycles(int'($urandom_range(150, 260)));
        end

        $display("[TB] reset during pause");
        apply_stimulus(8'b11_10_01_00, 9, 1'b0, 32'd0);
        run_cycles(2);
        apply_stimulus(8'b11_10_01_00, 9, 1'b1, 32'hA5);
        run_cycles(1 + 8 * SLOT_LEN + 20);
        async_reset_check();
        run_cycles(3);
        rst_n = 1'b1;
        run_cycles(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_led_status_ctrl.md
FPGA_LED_STATUS_CTRL -- requirements
Module: fpga_led_status_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 4, number of independent LED channels (1..16).
REQ-002 Parameter CNT_W, default 27, free-running counter width; blink period 2^CNT_W cycles.
REQ-003 Parameter PWM_W, default 8, PWM resolution in bits; SHALL be < CNT_W.
REQ-004 Parameter SLOT_W, default 24, exit-code bit-slot length 2^SLOT_W cycles; SHALL be >= 2.
REQ-005 clk_gen  input  1  system clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 mode_i  input  2*NUM_LEDS  per-channel mode: 00 off, 01 on, 10 blink, 11 PWM.
REQ-008 duty_i  input  PWM_W  PWM duty, shared by all channels.
REQ-009 exit_valid_i  input  1  level, program-finished indication.
REQ-010 exit_value_i  input  32  program exit code.
REQ-011 rst_sync_no  output  1  synchronised reset for downstream logic.
REQ-012 led_o  output  NUM_LEDS  registered LED drive.
REQ-013 exit_led_o  output  1  serial exit-code blink.
REQ-014 exit_ok_o  output  1  high when exit_valid_i and exit code == 0.

Function
REQ-015 rst_sync_no SHALL come from a 2-flop synchroniser: asserts (0) asynchronously with rst_n, deasserts on the 2nd rising clk_gen after rst_n rises.
REQ-016 All other state SHALL be reset by rst_n.
REQ-017 Counter cnt (CNT_W bits) SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 led_o[i] SHALL be registered, 1-cycle latency from mode_i/duty_i/cnt.
REQ-019 Mode 00 SHALL drive 0; mode 01 SHALL drive 1; mode 10 SHALL drive cnt[CNT_W-1].
REQ-020 Mode 11 SHALL drive (cnt[PWM_W-1:0] < duty_i): duty 0 -> always 0; duty all-ones -> 1 for (2^PWM_W - 1) of every 2^PWM_W cycles.
REQ-021 Mode changes SHALL take effect on the next clock edge without resetting cnt.
REQ-022 Exit FSM states: IDLE, BIT, PAUSE.
REQ-023 IDLE: exit_led_o = 0; on exit_valid_i = 1, latch code = exit_value_i[7:0], bit index = 7, slot counter = 0, go to BIT.
REQ-024 BIT: slot counter (SLOT_W bits) increments every cycle; exit_led_o = 1 while slot counter < 3*2^(SLOT_W-2) if code[idx] = 1, or < 2^(SLOT_W-2) if code[idx] = 0; 0 otherwise.
REQ-025 BIT: at slot counter wrap, idx decrements; at wrap with idx = 0, go to PAUSE.
REQ-026 PAUSE: exit_led_o = 0 for exactly 4 slots (4*2^SLOT_W cycles), then BIT with idx = 7, same latched code (no re-sample).
REQ-027 exit_valid_i = 0 in BIT or PAUSE SHALL return FSM to IDLE on the next edge, exit_led_o = 0 from that edge.
REQ-028 exit_led_o SHALL be registered, 1-cycle latency from FSM state/counters.
REQ-029 exit_ok_o SHALL be registered: exit_valid_i & (exit_value_i == 0), updated every cycle.

Reset
REQ-030 During rst_n = 0: rst_sync_no = 0, led_o = 0, exit_led_o = 0, exit_ok_o = 0, cnt = 0, FSM = IDLE, latched code = 0.
REQ-031 Reset asserted mid-sequence SHALL abort immediately; after release, sequence restarts only via IDLE.

Structure
REQ-032 Shared package SHALL hold the LED mode enum (OFF, ON, BLINK, PWM) and the exit FSM state enum.
REQ-033 One sub-module, fpga_led_exit_blinker, SHALL contain the exit FSM (REQ-022..028); channel logic and synchroniser stay in the top.

Verification (CNT_W=6, PWM_W=4, SLOT_W=4, NUM_LEDS=4)
REQ-034 Reset release -> rst_sync_no rises exactly 2 edges later; all outputs 0 during reset.
REQ-035 mode_i = 8'b11_10_01_00, duty_i = 4 -> led_o[0]=0, led_o[1]=1, led_o[2] toggles every 32 cycles, led_o[3] high 4 of every 16 cycles.
REQ-036 duty_i = 0 and 15 in PWM mode -> 0/16 and 15/16 high cycles per period.
REQ-037 exit_valid_i=1, exit_value_i=32'hA5 -> 8 slots of 16 cycles, high-times 12,4,12,4,4,12,4,12, then 64 low cycles, then repeat; exit_ok_o = 0.
REQ-038 exit_valid_i dropped during slot 3 -> exit_led_o = 0 next cycle, FSM IDLE; re-assert with 0 -> exit_ok_o = 1, pattern of eight 4-cycle pulses.
REQ-039 rst_n pulsed during PAUSE -> all outputs 0 asynchronously; cnt restarts from 0.
